tsdram_client: RTL and testbench

Host-side initiator for the tiny SDRAM controller. It converts single 16-bit host read/write transactions into controller cmd_req/cmd_ack handshakes. It also captures the BL-word read burst from data_valid/cmd_dout and returns the requested word. It sits between a CPU/bus bridge and the SDRAM controller, and can optionally keep the last burst as a one-line read cache.

---
 rtl/tsdram_pkg.sv | 28 ++
 rtl/tsdram_client_if.sv | 40 ++++
 rtl/tsdram_line_buf.sv | 51 +++++
 rtl/tsdram_client.sv | 202 ++++++++++++++++++++
 tb/tb_tsdram_client.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tsdram_pkg.sv
// tsdram_client shared types: controller command codes,
// client FSM states and burst-length helpers.
package tsdram_pkg;

  typedef enum logic [1:0] {
    CMD_NOP = 2'b00,
    CMD_WRB = 2'b01,
    CMD_RD  = 2'b10,
    CMD_WRW = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_BURST,
    S_DONE
  } state_t;

  localparam int BL_DEF = 4;

  function automatic int bl_log2(input int bl);
    return $clog2(bl);
  endfunction

  localparam int BL_LOG2 = bl_log2(BL_DEF);

endpackage

// File: rtl/tsdram_client_if.sv
// Host bus plus SDRAM controller command bus of tsdram_client.
// slave = the client itself, master = host and controller side.
interface tsdram_client_if #(
  parameter int ADDR_BITS = 32
);
  logic                 host_req;
  logic                 host_we;
  logic [1:0]           host_be;
  logic [ADDR_BITS-1:0] host_addr;
  logic [15:0]          host_wdata;
  logic                 host_ready;
  logic [15:0]          host_rdata;
  logic                 host_rvalid;
  logic                 busy;
  logic [1:0]           cmd_req;
  logic                 cmd_ack;
  logic [1:0]           cmd_mask;
  logic [ADDR_BITS-1:0] cmd_addr;
  logic [15:0]          cmd_din;
  logic [15:0]          cmd_dout;
  logic                 data_valid;

  modport slave (
    input  host_req, host_we, host_be,
    input  host_addr, host_wdata,
    input  cmd_ack, cmd_dout, data_valid,
    output host_ready, host_rdata, host_rvalid,
    output busy, cmd_req, cmd_mask,
    output cmd_addr, cmd_din
  );

  modport master (
    output host_req, host_we, host_be,
    output host_addr, host_wdata,
    output cmd_ack, cmd_dout, data_valid,
    input  host_ready, host_rdata, host_rvalid,
    input  busy, cmd_req, cmd_mask,
    input  cmd_addr, cmd_din
  );
endinterface

// File: rtl/tsdram_line_buf.sv
// One-line read cache: BL x 16 words, byte-merge write port,
// tag/valid and hit compare for tsdram_client.
module tsdram_line_buf
  import tsdram_pkg::*;
#(
  parameter int LG = BL_LOG2,
  parameter int TW = 29
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inv,
  input  logic          wr_en,
  input  logic [LG-1:0] wr_idx,
  input  logic [15:0]   wr_data,
  input  logic [1:0]    wr_be,
  input  logic          set,
  input  logic [TW-1:0] set_tag,
  input  logic [TW-1:0] lk_tag,
  input  logic [LG-1:0] lk_idx,
  output logic          hit,
  output logic [15:0]   rd_word
);

  logic [15:0]   line_q [1<<LG];
  logic [TW-1:0] tag_q;
  logic          valid_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_be[0]) line_q[wr_idx][7:0]  <= wr_data[7:0];
      if (wr_be[1]) line_q[wr_idx][15:8] <= wr_data[15:8];
    end
  end

  // valid only after a complete burst; any miss drops it
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
    end else if (inv) begin
      valid_q <= 1'b0;
    end else if (set) begin
      valid_q <= 1'b1;
      tag_q   <= set_tag;
    end
  end

  assign hit     = valid_q && (tag_q == lk_tag);
  assign rd_word = line_q[lk_idx];

endmodule

// File: rtl/tsdram_client.sv
// Host-side initiator for the tiny SDRAM controller.
// Optional one-line read cache: TSDRAM_CLIENT_LINE_CACHE_EN.
module tsdram_client
  import tsdram_pkg::*;
#(
  parameter int BL        = BL_DEF,
  parameter int ADDR_BITS = 32
) (
  input logic            clk,
  input logic            reset,
  tsdram_client_if.slave bus
);

  localparam int LG = bl_log2(BL);

  state_t               state_q, state_d;
  cmd_t                 req_q, req_d;
  logic [LG-1:0]        k_q, k_d;
  logic [1:0]           mask_q, mask_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [15:0]          din_q, din_d;
  logic [15:0]          rdata_q, rdata_d;
  logic                 ready_q, ready_d;
  logic                 rvalid_q, rvalid_d;
  logic                 busy_q;
  logic                 accept, last_beat, rd_hit;
  logic [15:0]          hit_word;

  // ready_q blocks re-acceptance of a request still held high
  assign accept = (state_q == S_IDLE) && bus.host_req
               && !ready_q;
  assign last_beat = (state_q == S_BURST) && bus.data_valid
                  && (k_q == LG'(BL-1));

`ifdef TSDRAM_CLIENT_LINE_CACHE_EN
  localparam int TW = ADDR_BITS - LG - 1;

  logic          lb_wr, lb_inv, lb_hit;
  logic [LG-1:0] lb_idx;
  logic [15:0]   lb_data;
  logic [1:0]    lb_be;

  always_comb begin
    lb_wr   = 1'b0;
    lb_idx  = bus.host_addr[LG:1];
    lb_data = bus.host_wdata;
    lb_be   = bus.host_be;
    if (state_q == S_BURST && bus.data_valid) begin
      lb_wr   = 1'b1;
      lb_idx  = addr_q[LG:1] + k_q;
      lb_data = bus.cmd_dout;
      lb_be   = 2'b11;
    end else if (accept && bus.host_we && lb_hit) begin
      lb_wr = 1'b1;
    end
  end

  assign lb_inv = accept && !bus.host_we && !lb_hit;
  assign rd_hit = lb_hit;

  tsdram_line_buf #(
    .LG (LG),
    .TW (TW)
  ) u_line (
    .clk     (clk),
    .reset   (reset),
    .inv     (lb_inv),
    .wr_en   (lb_wr),
    .wr_idx  (lb_idx),
    .wr_data (lb_data),
    .wr_be   (lb_be),
    .set     (last_beat),
    .set_tag (addr_q[ADDR_BITS-1:LG+1]),
    .lk_tag  (bus.host_addr[ADDR_BITS-1:LG+1]),
    .lk_idx  (bus.host_addr[LG:1]),
    .hit     (lb_hit),
    .rd_word (hit_word)
  );
`else
  assign rd_hit   = 1'b0;
  assign hit_word = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      req_q    <= CMD_NOP;
      k_q      <= '0;
      mask_q   <= 2'b11;
      addr_q   <= '0;
      din_q    <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      k_q      <= k_d;
      mask_q   <= mask_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      busy_q   <= (state_d != S_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.host_we && bus.host_be != 2'b00)
            state_d = S_WR;
          else if (!bus.host_we && !rd_hit)
            state_d = S_RD;
        end
      end
      S_WR:
        if (bus.cmd_ack) state_d = S_DONE;
      S_RD:
        if (bus.cmd_ack) state_d = S_BURST;
      S_BURST: begin
        // a short burst leaves the line unloaded
        if (last_beat)
          state_d = S_DONE;
        else if (!bus.data_valid && k_q != '0)
          state_d = S_DONE;
      end
      S_DONE:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_d    = req_q;
    k_d      = k_q;
    mask_d   = mask_q;
    addr_d   = addr_q;
    din_d    = din_q;
    rdata_d  = rdata_q;
    ready_d  = 1'b0;
    rvalid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d = bus.host_addr;
          din_d  = bus.host_wdata;
          mask_d = ~bus.host_be;
          unique case (1'b1)
            bus.host_we && bus.host_be == 2'b00:
              ready_d = 1'b1;
            bus.host_we && bus.host_be != 2'b00:
              req_d = (bus.host_be == 2'b11)
                    ? CMD_WRW : CMD_WRB;
            !bus.host_we && rd_hit: begin
              rdata_d  = hit_word;
              rvalid_d = 1'b1;
              ready_d  = 1'b1;
            end
            !bus.host_we && !rd_hit:
              req_d = CMD_RD;
          endcase
        end
      end
      S_WR:
        if (bus.cmd_ack) req_d = CMD_NOP;
      S_RD: begin
        if (bus.cmd_ack) begin
          req_d = CMD_NOP;
          k_d   = '0;
        end
      end
      S_BURST: begin
        if (bus.data_valid) begin
          k_d = k_q + LG'(1);
          if (k_q == '0) begin
            rdata_d  = bus.cmd_dout;
            rvalid_d = 1'b1;
          end
        end
      end
      S_DONE:
        ready_d = 1'b1;
      default: ;
    endcase
  end

  assign bus.cmd_req     = req_q;
  assign bus.cmd_mask    = mask_q;
  assign bus.cmd_addr    = addr_q;
  assign bus.cmd_din     = din_q;
  assign bus.host_rdata  = rdata_q;
  assign bus.host_ready  = ready_q;
  assign bus.host_rvalid = rvalid_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_tsdram_client.sv
// Scoreboard bench for tsdram_client: directed host/controller
// vectors, monitor pops expected rvalid/ready events.
module tb_tsdram_client;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  tsdram_client_if #(.ADDR_BITS(32)) bus ();

  tsdram_client #(
    .BL        (4),
    .ADDR_BITS (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          is_rd;
    logic [15:0] data;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cmd_count = 0;
  logic [1:0] prev_req = 2'b00;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic push_rd(input logic [15:0] d);
    exp_t e;
    e.is_rd = 1'b1;
    e.data  = d;
    q.push_back(e);
  endtask

  task automatic push_ready();
    exp_t e;
    e.is_rd = 1'b0;
    e.data  = '0;
    q.push_back(e);
  endtask

  // monitor: every rvalid/ready pulse must match the queue head
  always @(negedge clk) begin
    if (bus.host_rvalid === 1'b1) begin
      checks++;
      if (q.size() == 0 || !q[0].is_rd) begin
        failures++;
        $display("FAIL sb_rvalid: unexpected rvalid data %h",
                 bus.host_rdata);
      end else begin
        if (bus.host_rdata !== q[0].data) begin
          failures++;
          $display("FAIL sb_rdata: got %h expected %h",
                   bus.host_rdata, q[0].data);
        end
        void'(q.pop_front());
      end
    end
    if (bus.host_ready === 1'b1) begin
      checks++;
      if (q.size() == 0 || q[0].is_rd) begin
        failures++;
        $display("FAIL sb_ready: unexpected ready, got 1 expected %0s",
                 q.size() == 0 ? "none" : "rvalid first");
      end else begin
        void'(q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (bus.cmd_req != 2'b00 && prev_req == 2'b00)
      cmd_count++;
    prev_req = bus.cmd_req;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_txn(input logic we,
                           input logic [1:0] be,
                           input logic [31:0] addr,
                           input logic [15:0] wd);
    bus.host_req   = 1'b1;
    bus.host_we    = we;
    bus.host_be    = be;
    bus.host_addr  = addr;
    bus.host_wdata = wd;
    tick();
  endtask

  task automatic ctrl_ack(input int dly,
                          input logic [1:0] exp_req);
    bit stable = 1'b1;
    repeat (dly) begin
      if (bus.cmd_req !== exp_req) stable = 1'b0;
      tick();
    end
    chk("req_hold", 32'(stable), 32'd1);
    bus.cmd_ack = 1'b1;
    tick();
    bus.cmd_ack = 1'b0;
    chk("req_drop", 32'(bus.cmd_req), 32'd0);
  endtask

  task automatic burst(input logic [15:0] base,
                       input int nw);
    for (int i = 0; i < nw; i++) begin
      bus.data_valid = 1'b1;
      bus.cmd_dout   = base + 16'(i);
      tick();
    end
    bus.data_valid = 1'b0;
    bus.cmd_dout   = '0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus.host_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    bus.host_req = 1'b0;
    tick();
  endtask

  int n;
  int c0;

  initial begin
    reset          = 1'b1;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_be    = 2'b00;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.cmd_ack    = 1'b0;
    bus.cmd_dout   = '0;
    bus.data_valid = 1'b0;
    repeat (3) tick();

    chk("rst_req", 32'(bus.cmd_req), 32'd0);
    chk("rst_mask", 32'(bus.cmd_mask), 32'd3);
    chk("rst_addr", bus.cmd_addr, 32'd0);
    chk("rst_din", 32'(bus.cmd_din), 32'd0);
    chk("rst_ready", 32'(bus.host_ready), 32'd0);
    chk("rst_rvalid", 32'(bus.host_rvalid), 32'd0);
    chk("rst_rdata", 32'(bus.host_rdata), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    tick();

    // write word
    c0 = cmd_count;
    push_ready();
    start_txn(1'b1, 2'b11, 32'h0000_1234, 16'hBEEF);
    chk("ww_req", 32'(bus.cmd_req), 32'd3);
    chk("ww_mask", 32'(bus.cmd_mask), 32'd0);
    chk("ww_addr", bus.cmd_addr, 32'h1234);
    chk("ww_din", 32'(bus.cmd_din), 32'hBEEF);
    chk("ww_busy", 32'(bus.busy), 32'd1);
    ctrl_ack(3, 2'b11);
    wait_ready(n);
    chk("ww_lat", n, 1);
    chk("ww_cmds", cmd_count - c0, 1);

    // write low byte
    push_ready();
    start_txn(1'b1, 2'b01, 32'h10, 16'h0012);
    chk("wb_req", 32'(bus.cmd_req), 32'd1);
    chk("wb_mask", 32'(bus.cmd_mask), 32'd2);
    ctrl_ack(2, 2'b01);
    wait_ready(n);
    chk("wb_lat", n, 1);

    // write with no byte enables
    c0 = cmd_count;
    push_ready();
    start_txn(1'b1, 2'b00, 32'h14, 16'hFFFF);
    chk("w0_req", 32'(bus.cmd_req), 32'd0);
    chk("w0_busy", 32'(bus.busy), 32'd0);
    wait_ready(n);
    chk("w0_lat", n, 0);
    chk("w0_cmds", cmd_count - c0, 0);

    // wrapped read burst, start word 3
    push_rd(16'h00A0);
    push_ready();
    start_txn(1'b0, 2'b11, 32'h6, 16'h0);
    chk("rd_req", 32'(bus.cmd_req), 32'd2);
    ctrl_ack(3, 2'b10);
    burst(16'h00A0, 4);
    wait_ready(n);
    chk("rd_lat", n, 1);

`ifdef TSDRAM_CLIENT_LINE_CACHE_EN
    // 0x2 is word 1 -> line[1] holds the third beat
    c0 = cmd_count;
    push_rd(16'h00A2);
    push_ready();
    start_txn(1'b0, 2'b11, 32'h2, 16'h0);
    wait_ready(n);
    chk("hit_lat", n, 0);
    chk("hit_cmds", cmd_count - c0, 0);
    push_ready();
    start_txn(1'b1, 2'b10, 32'h2, 16'h5512);
    chk("wh_req", 32'(bus.cmd_req), 32'd1);
    ctrl_ack(2, 2'b01);
    wait_ready(n);
    c0 = cmd_count;
    push_rd(16'h55A2);
    push_ready();
    start_txn(1'b0, 2'b11, 32'h2, 16'h0);
    wait_ready(n);
    chk("merge_cmds", cmd_count - c0, 0);
`endif

    // data_valid while idle is ignored
    bus.data_valid = 1'b1;
    bus.cmd_dout   = 16'hFFFF;
    repeat (3) tick();
    chk("idle_dv_busy", 32'(bus.busy), 32'd0);
    chk("idle_dv_rv", 32'(bus.host_rvalid), 32'd0);
    bus.data_valid = 1'b0;
    bus.cmd_dout   = '0;

    // slow ack: one command held stable for 20 cycles
    c0 = cmd_count;
    push_rd(16'h00C0);
    push_ready();
    start_txn(1'b0, 2'b11, 32'h20, 16'h0);
    ctrl_ack(20, 2'b10);
    burst(16'h00C0, 4);
    wait_ready(n);
    chk("slow_lat", n, 1);
    chk("slow_cmds", cmd_count - c0, 1);

    // burst cut short after two words
    push_rd(16'h00D0);
    push_ready();
    start_txn(1'b0, 2'b11, 32'h40, 16'h0);
    ctrl_ack(1, 2'b10);
    burst(16'h00D0, 2);
    wait_ready(n);
    chk("short_lat", n, 2);

    // reset on the second burst word
    push_rd(16'h00E0);
    start_txn(1'b0, 2'b11, 32'h60, 16'h0);
    ctrl_ack(1, 2'b10);
    bus.data_valid = 1'b1;
    bus.cmd_dout   = 16'h00E0;
    tick();
    bus.cmd_dout = 16'h00E1;
    reset        = 1'b1;
    bus.host_req = 1'b0;
    tick();
    reset = 1'b0;
    chk("mid_rst_req", 32'(bus.cmd_req), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    bus.cmd_dout = 16'h00E2;
    tick();
    bus.cmd_dout = 16'h00E3;
    tick();
    bus.data_valid = 1'b0;
    bus.cmd_dout   = '0;
    repeat (3) tick();
    chk("post_rst_busy", 32'(bus.busy), 32'd0);

`ifdef TSDRAM_CLIENT_LINE_CACHE_EN
    // reset dropped the line, so this must miss
    c0 = cmd_count;
    push_rd(16'h00F0);
    push_ready();
    start_txn(1'b0, 2'b11, 32'h2, 16'h0);
    ctrl_ack(1, 2'b10);
    burst(16'h00F0, 4);
    wait_ready(n);
    chk("rst_miss_cmds", cmd_count - c0, 1);
`endif

    repeat (2) tick();
    chk("sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
